// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared definitions for the shift sequencer: R-type shift
//                funct codes, the sequencer state encoding, the shift kind
//                decode and a 32-bit bit-reverse helper.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_pkg;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      KIND_LEFT    = 2'd0,
      KIND_LOGIC   = 2'd1,
      KIND_ARITH   = 2'd2,
      KIND_ILLEGAL = 2'd3
   } kind_t;

   function automatic logic [31:0] rev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   function automatic kind_t decode_kind(input logic [5:0] fn);
      kind_t k;
      case (fn)
         FN_SLL, FN_SLLV: k = KIND_LEFT;
         FN_SRL, FN_SRLV: k = KIND_LOGIC;
         FN_SRA, FN_SRAV: k = KIND_ARITH;
         default:         k = KIND_ILLEGAL;
      endcase
      return k;
   endfunction

   // Variable forms take their amount from rs instead of the shamt field.
   function automatic logic is_var_form(input logic [5:0] fn);
      return (fn == FN_SLLV) || (fn == FN_SRLV) || (fn == FN_SRAV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/shift_operator.sv
`default_nettype none
// ============================================================================
//  Module      : shift_operator
//  Description : Combinational 32-bit arithmetic right shifter.
//  Ports       : b     in  32  operand
//                shamt in   5  shift amount (0..31)
//                res   out 32  b >>> shamt (sign-filling)
//  Revision    : 1.0  initial release
// ============================================================================
module shift_operator (
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   output logic [31:0] res
);

   assign res = $signed(b) >>> shamt;

endmodule
`default_nettype wire

// File: rtl/shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_ctrl
//  Description : Three-state sequencer for R-type shift instructions. Latches
//                the operands, derives SLL/SRL/SRA from a single arithmetic
//                right shifter and returns a registered result with a
//                busy/done handshake.
//  Ports       : clk       in   1  clock, rising edge
//                rst_n     in   1  asynchronous active-low reset
//                start     in   1  request, sampled only in IDLE
//                funct     in   6  instruction funct field
//                shamt_imm in   5  immediate shift amount
//                rs_val    in  32  variable amount source (bits 4:0 used)
//                rt_val    in  32  operand to shift
//                busy      out  1  high in SHIFT and DONE
//                done      out  1  one-cycle completion pulse
//                result    out 32  registered result, held until next done
//                illegal   out  1  funct was not a shift code
//  Revision    : 1.0  initial release
// ============================================================================
module shift_ctrl
   import shift_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [5:0]  funct,
   input  logic [4:0]  shamt_imm,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        illegal
);

   state_t      state, state_nxt;
   logic [5:0]  op_q;
   logic [31:0] b_q;
   logic [4:0]  amt_q;

   kind_t       kind;
   logic [31:0] shifter_in;
   logic [31:0] shifter_out;
   logic [31:0] mask;
   logic [31:0] shift_val;

   // Only the low five rs bits form the amount; the rest are don't-care.
   logic        unused_rs_hi;
   assign unused_rs_hi = ^rs_val[31:5];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // ------------------------------------------------------ operand latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= 6'd0;
         b_q   <= 32'd0;
         amt_q <= 5'd0;
      end else if (state == IDLE && start) begin
         op_q  <= funct;
         b_q   <= rt_val;
         amt_q <= is_var_form(funct) ? rs_val[4:0] : shamt_imm;
      end
   end

   // ------------------------------------------------------- datapath
   // A left shift is a right shift of the bit-reversed operand, reversed
   // back; the zero mask turns the arithmetic fill into a logical one.
   assign kind       = decode_kind(op_q);
   assign shifter_in = (kind == KIND_LEFT) ? rev32(b_q) : b_q;
   assign mask       = 32'hFFFF_FFFF >> amt_q;

   shift_operator u_shift_operator (
      .b     (shifter_in),
      .shamt (amt_q),
      .res   (shifter_out)
   );

   always_comb begin
      shift_val = 32'd0;
      case (kind)
         KIND_ARITH: shift_val = shifter_out;
         KIND_LOGIC: shift_val = shifter_out & mask;
         KIND_LEFT:  shift_val = rev32(shifter_out & mask);
         default:    shift_val = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result  <= 32'd0;
         illegal <= 1'b0;
      end else if (state == SHIFT) begin
         result  <= shift_val;
         illegal <= (kind == KIND_ILLEGAL);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_ctrl
//  Description : Self-checking bench for shift_ctrl. A behavioural model
//                predicts busy/done/result/illegal every cycle; directed
//                operations pin the model with literal results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  funct = 6'd0;
   logic [4:0]  shamt_imm = 5'd0;
   logic [31:0] rs_val = 32'd0;
   logic [31:0] rt_val = 32'd0;
   logic        busy, done, illegal;
   logic [31:0] result;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   shift_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .funct     (funct),
      .shamt_imm (shamt_imm),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .illegal   (illegal)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain shift operators. Returns {illegal, result}.
   function automatic logic [32:0] ref_op(input logic [5:0] f, input logic [4:0] sh,
                                          input logic [31:0] rs, input logic [31:0] rt);
      logic [31:0] r;
      logic [4:0]  a;
      a = rs[4:0];
      case (f)
         6'h00: return {1'b0, rt << sh};
         6'h02: return {1'b0, rt >> sh};
         6'h03: begin r = $signed(rt) >>> sh; return {1'b0, r}; end
         6'h04: return {1'b0, rt << a};
         6'h06: return {1'b0, rt >> a};
         6'h07: begin r = $signed(rt) >>> a; return {1'b0, r}; end
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   // Model: cycles remaining in the operation (2 = computing, 1 = done).
   int          m_left;
   logic [32:0] m_pend;
   logic [31:0] m_result;
   logic        m_illegal;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left    <= 0;
         m_pend    <= 33'd0;
         m_result  <= 32'd0;
         m_illegal <= 1'b0;
      end else if (m_left == 0) begin
         if (start) begin
            m_left <= 2;
            m_pend <= ref_op(funct, shamt_imm, rs_val, rt_val);
         end
      end else if (m_left == 2) begin
         m_left    <= 1;
         m_result  <= m_pend[31:0];
         m_illegal <= m_pend[32];
      end else begin
         m_left <= 0;
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      check("busy",    {31'd0, busy},    {31'd0, (m_left != 0)});
      check("done",    {31'd0, done},    {31'd0, (m_left == 1)});
      check("result",  result,           m_result);
      check("illegal", {31'd0, illegal}, {31'd0, m_illegal});
   end

   int done_cnt;
   always @(negedge clk) if (done) done_cnt++;

   // Issue one operation, wait (bounded) for done, check literals.
   task automatic run_op(input string name, input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic scramble, input logic [31:0] exp_res, input logic exp_ill);
      bit seen = 0;
      @(negedge clk);
      funct = f; shamt_imm = sh; rs_val = rs; rt_val = rt; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (scramble) begin
         rt_val = ~rt; rs_val = ~rs; shamt_imm = ~sh; funct = 6'h3F;
      end
      for (int i = 0; i < 5 && !seen; i++) begin
         if (done) begin
            seen = 1;
            check({name, "_result"}, result, exp_res);
            check({name, "_illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
            check({name, "_model"}, m_result, exp_res);
         end else begin
            @(negedge clk);
         end
      end
      check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
      @(negedge clk);
      check({name, "_done_width"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int ops;
      repeat (2) @(negedge clk);
      check("rst_busy",   {31'd0, busy},    32'd0);
      check("rst_done",   {31'd0, done},    32'd0);
      check("rst_result", result,           32'd0);
      check("rst_ill",    {31'd0, illegal}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);

      run_op("sra",      6'h03, 5'd4,  32'h0,         32'h8000_00F0, 0, 32'hF800_000F, 0);
      run_op("srlv",     6'h06, 5'd0,  32'hFFFF_FFE4, 32'h8000_00F0, 0, 32'h0800_000F, 0);
      run_op("sll31",    6'h00, 5'd31, 32'h0,         32'h0000_0001, 0, 32'h8000_0000, 0);
      run_op("sll0",     6'h00, 5'd0,  32'h0,         32'h0000_0001, 0, 32'h0000_0001, 0);
      run_op("sllv0",    6'h04, 5'd9,  32'hFFFF_FFE0, 32'h1234_5678, 0, 32'h1234_5678, 0);
      run_op("srav31",   6'h07, 5'd0,  32'h0000_001F, 32'h8000_0000, 0, 32'hFFFF_FFFF, 0);
      run_op("srl31",    6'h02, 5'd31, 32'h0,         32'h8000_0000, 0, 32'h0000_0001, 0);
      run_op("illegal",  6'h20, 5'd3,  32'h0,         32'hDEAD_BEEF, 0, 32'h0000_0000, 1);
      run_op("clr_ill",  6'h03, 5'd4,  32'h0,         32'h8000_00F0, 0, 32'hF800_000F, 0);
      run_op("scramble", 6'h04, 5'd0,  32'h0000_0008, 32'h0000_00AB, 1, 32'h0000_AB00, 0);

      // Reset in the middle of SHIFT: outputs clear at once, no done follows.
      @(negedge clk);
      funct = 6'h03; shamt_imm = 5'd1; rt_val = 32'hF000_0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy",   {31'd0, busy}, 32'd0);
      check("abort_result", result,        32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      done_cnt = 0;
      repeat (5) @(negedge clk);
      check("abort_no_done", done_cnt, 32'd0);

      // Start held high: one acceptance every three cycles.
      funct = 6'h02; shamt_imm = 5'd3; rt_val = 32'hFF00_FF00; start = 1'b1;
      done_cnt = 0;
      repeat (30) @(negedge clk);
      check("cont_done_count", done_cnt, 32'd10);
      start = 1'b0;
      repeat (3) @(negedge clk);

      // Randomized traffic, checked cycle by cycle by the model.
      ops = 0;
      for (int c = 0; c < 800; c++) begin
         start = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 7))
            0: funct = 6'h00;
            1: funct = 6'h02;
            2: funct = 6'h03;
            3: funct = 6'h04;
            4: funct = 6'h06;
            5: funct = 6'h07;
            default: funct = 6'($urandom);
         endcase
         shamt_imm = 5'($urandom);
         rs_val = $urandom;
         rt_val = $urandom;
         if (done) ops++;
         @(negedge clk);
      end
      start = 1'b0;
      check("random_ops_nonzero", {31'd0, (ops > 50)}, 32'd1);
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
